clk_div_bank: RTL and testbench

Parametrised multi-channel clock-divider bank generating slow sample and converter clocks, for example the ADC0809 conversion clock, from the 25 MHz system clock. Each channel has a runtime-programmable half-period, a glitch-free divisor update at period boundaries, registered rise/fall strobes for same-domain logic, and a global sync that phase-aligns all channels. It sits between the system clock and the converter control FSMs.

---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clk_div_bank_if.sv | 34 +++
 rtl/clk_div_ch.sv | 66 ++++++
 rtl/clk_div_bank.sv | 36 +++
 tb/tb_clk_div_bank.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and helpers for the clock-divider bank
//   DEF_W    default half-period counter width
//   DEF_HALF reset half-period N (25 MHz / (2*(N+1)) ~ 446 kHz)
//   ch_w()   width of a channel index, never below 1
package clk_div_pkg;
    localparam int DEF_W = 8;
    localparam int DEF_HALF = 27;
    function automatic int ch_w(input int ch);
        return ch > 1 ? $clog2(ch) : 1;
    endfunction
endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: control and output bundle of the clock-divider bank
//   en        per-channel run enable
//   sync      one-cycle pulse restarting all channels in phase
//   wr_valid  divisor write strobe (always accepted)
//   wr_ch     target channel of the write
//   wr_half   new half-period value N
//   clk_out   divided clocks
//   rise_tick strobe in the cycle clk_out goes high
//   fall_tick strobe in the cycle clk_out goes low
//   pending   shadow divisor written but not yet applied
interface clk_div_bank_if
    import clk_div_pkg::*;
#(
    parameter int CH = 2,
    parameter int W = DEF_W
);
    logic [CH-1:0]       en;
    logic                sync;
    logic                wr_valid;
    logic [ch_w(CH)-1:0] wr_ch;
    logic [W-1:0]        wr_half;
    logic [CH-1:0]       clk_out;
    logic [CH-1:0]       rise_tick;
    logic [CH-1:0]       fall_tick;
    logic [CH-1:0]       pending;
    modport master (
        output en, sync, wr_valid, wr_ch, wr_half,
        input  clk_out, rise_tick, fall_tick, pending
    );
    modport slave (
        input  en, sync, wr_valid, wr_ch, wr_half,
        output clk_out, rise_tick, fall_tick, pending
    );
endinterface

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with shadowed divisor applied at period end
//   clk, rst  system clock, asynchronous active-low reset
//   en        run enable; when low the phase freezes and a pending divisor applies
//   sync      restart: cnt and clk_out to 0, pending divisor applied, no ticks
//   wr_hit    write addressed to this channel
//   wr_half   new half-period N
//   clk_out   divided clock, ratio 2*(N+1)
//   rise_tick / fall_tick registered edge strobes
//   pending   shadow holds a divisor not yet in use
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int HALF_DEFAULT = DEF_HALF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sync,
    input  logic         wr_hit,
    input  logic [W-1:0] wr_half,
    output logic         clk_out,
    output logic         rise_tick,
    output logic         fall_tick,
    output logic         pending
);
    logic [W-1:0] cnt, half, shadow, next_half;
    logic tc, fall_pt;
    // >= rather than == so a divisor shrunk while disabled cannot let cnt run past half
    assign tc = cnt >= half;
    assign fall_pt = tc && clk_out;
    // a write landing on an apply point is forwarded straight into the active divisor
    always_comb next_half = wr_hit ? wr_half : pending ? shadow : half;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt       <= '0;
            half      <= W'(HALF_DEFAULT);
            shadow    <= W'(HALF_DEFAULT);
            pending   <= 1'b0;
            clk_out   <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            shadow <= wr_hit ? wr_half : shadow;
            if (sync) begin
                cnt       <= '0;
                clk_out   <= 1'b0;
                rise_tick <= 1'b0;
                fall_tick <= 1'b0;
                half      <= next_half;
                pending   <= 1'b0;
            end else if (!en) begin
                rise_tick <= 1'b0;
                fall_tick <= 1'b0;
                half      <= pending ? shadow : half;
                pending   <= wr_hit;
            end else begin
                cnt       <= tc ? '0 : cnt + W'(1);
                clk_out   <= clk_out ^ tc;
                rise_tick <= tc && !clk_out;
                fall_tick <= fall_pt;
                half      <= fall_pt ? next_half : half;
                pending   <= fall_pt ? 1'b0 : pending || wr_hit;
            end
        end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: CH independent programmable clock dividers with global sync
//   clk, rst  system clock, asynchronous active-low reset
//   bus       clk_div_bank_if slave: enables, sync, divisor writes, divided clocks and strobes
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int CH = 2,
    parameter int W = DEF_W,
    parameter int HALF_DEFAULT = DEF_HALF
) (
    input logic           clk,
    input logic           rst,
    clk_div_bank_if.slave bus
);
    localparam int CW = ch_w(CH);
    genvar i;
    generate
        for (i = 0; i < CH; i++) begin : g_ch
            logic hit;
            // indices >= CH never match, so out-of-range writes are dropped
            assign hit = bus.wr_valid && bus.wr_ch == CW'(i);
            clk_div_ch #(.W(W), .HALF_DEFAULT(HALF_DEFAULT)) u_ch (
                .clk       (clk),
                .rst       (rst),
                .en        (bus.en[i]),
                .sync      (bus.sync),
                .wr_hit    (hit),
                .wr_half   (bus.wr_half),
                .clk_out   (bus.clk_out[i]),
                .rise_tick (bus.rise_tick[i]),
                .fall_tick (bus.fall_tick[i]),
                .pending   (bus.pending[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed self-checking bench for clk_div_bank (CH=3 so wr_ch=3 is out of range)
module tb_clk_div_bank;
    logic clk, rst;
    int vectors = 0;
    int miscompares = 0;
    clk_div_bank_if #(.CH(3), .W(8)) bus ();
    clk_div_bank #(.CH(3), .W(8), .HALF_DEFAULT(27)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic wr(input logic [1:0] ch, input logic [7:0] n);
        bus.wr_valid = 1'b1;
        bus.wr_ch = ch;
        bus.wr_half = n;
    endtask
    initial begin
        rst = 1'b0;
        bus.en = '0;
        bus.sync = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_ch = '0;
        bus.wr_half = '0;
        step(3);
        chk("rst_clk", 32'(bus.clk_out), 0);
        chk("rst_rise", 32'(bus.rise_tick), 0);
        chk("rst_fall", 32'(bus.fall_tick), 0);
        chk("rst_pend", 32'(bus.pending), 0);
        rst = 1'b1;
        step(1);
        bus.en = 3'b011;
        step(27);
        chk("pre_rise", 32'(bus.clk_out), 0);
        step(1);
        chk("rise0_clk", 32'(bus.clk_out), 3'b011);
        chk("rise0_tick", 32'(bus.rise_tick), 3'b011);
        step(1);
        chk("rise0_once", 32'(bus.rise_tick), 0);
        step(27);
        chk("fall0_clk", 32'(bus.clk_out), 0);
        chk("fall0_tick", 32'(bus.fall_tick), 3'b011);
        step(28);
        chk("rise1_tick", 32'(bus.rise_tick), 3'b011);
        step(5);
        wr(2'd0, 8'd0);
        step(1);
        bus.wr_valid = 1'b0;
        chk("pend_set", 32'(bus.pending), 3'b001);
        step(21);
        chk("pend_hold", 32'({bus.pending, bus.clk_out}), 6'b001_011);
        step(1);
        chk("apply_fall", 32'(bus.fall_tick), 3'b011);
        chk("apply_pend", 32'(bus.pending), 0);
        step(1);
        chk("n0_hi", 32'(bus.clk_out), 3'b001);
        chk("n0_rise", 32'(bus.rise_tick), 3'b001);
        wr(2'd3, 8'd9);
        step(1);
        bus.wr_valid = 1'b0;
        chk("n0_lo", 32'(bus.clk_out), 3'b000);
        wr(2'd3, 8'd9);
        step(1);
        bus.wr_valid = 1'b0;
        chk("bad_ch_pend", 32'(bus.pending), 0);
        chk("bad_ch_n0", 32'(bus.clk_out), 3'b001);
        wr(2'd1, 8'd4);
        step(1);
        bus.wr_valid = 1'b0;
        chk("ch1_pend", 32'(bus.pending), 3'b010);
        chk("ch1_n0", 32'(bus.clk_out), 3'b000);
        wr(2'd0, 8'd9);
        bus.sync = 1'b1;
        step(1);
        bus.wr_valid = 1'b0;
        bus.sync = 1'b0;
        chk("sync_clk", 32'(bus.clk_out), 0);
        chk("sync_pend", 32'(bus.pending), 0);
        chk("sync_ticks", 32'({bus.rise_tick, bus.fall_tick}), 0);
        step(4);
        chk("s4_clk", 32'(bus.clk_out), 0);
        step(1);
        chk("s5_clk", 32'(bus.clk_out), 3'b010);
        chk("s5_rise", 32'(bus.rise_tick), 3'b010);
        step(5);
        chk("s10_clk", 32'(bus.clk_out), 3'b001);
        chk("s10_ticks", 32'({bus.rise_tick, bus.fall_tick}), 6'b001_010);
        step(10);
        chk("s20_clk", 32'(bus.clk_out), 0);
        chk("s20_fall", 32'(bus.fall_tick), 3'b011);
        step(10);
        chk("s30_clk", 32'(bus.clk_out), 3'b001);
        chk("s30_ticks", 32'({bus.rise_tick, bus.fall_tick}), 6'b001_010);
        step(3);
        bus.en = 3'b010;
        for (int k = 0; k < 7; k++) begin
            step(1);
            chk("frozen", 32'({bus.clk_out[0], bus.rise_tick[0], bus.fall_tick[0]}), 3'b100);
        end
        bus.en = 3'b011;
        step(6);
        chk("resume_hold", 32'(bus.clk_out[0]), 1);
        step(1);
        chk("resume_fall", 32'({bus.clk_out[0], bus.fall_tick[0]}), 2'b01);
        step(2);
        wr(2'd1, 8'd2);
        step(1);
        bus.wr_valid = 1'b0;
        chk("fallwr_pend", 32'(bus.pending), 0);
        chk("fallwr_tick", 32'(bus.fall_tick[1]), 1);
        step(2);
        chk("fallwr_lo", 32'(bus.clk_out[1]), 0);
        step(1);
        chk("fallwr_rise", 32'({bus.clk_out[1], bus.rise_tick[1]}), 2'b11);
        step(1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_clk", 32'(bus.clk_out), 0);
        chk("async_rst_pend", 32'(bus.pending), 0);
        step(1);
        rst = 1'b1;
        step(27);
        chk("rerst_pre", 32'(bus.clk_out), 0);
        step(1);
        chk("rerst_rise", 32'(bus.clk_out), 3'b011);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
